// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle signed multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ADD_W = WIDTH + 1;
    localparam int unsigned CNT_W = 6;

    localparam logic [CNT_W-1:0] ITER_LAST = 6'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             exc;
    } res_t;

    // Two's-complement magnitude; -2^31 maps to 2^31 as an unsigned value.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute stage and multdiv_unit.
interface multdiv_if;
    import multdiv_pkg::*;

    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/multdiv_addsub.sv
// 33-bit adder/subtractor shared by the Booth and restoring-divide datapaths.
module multdiv_addsub
    import multdiv_pkg::*;
(
    input  logic [ADD_W-1:0] a_i,
    input  logic [ADD_W-1:0] b_i,
    input  logic             sub_i,
    output logic [ADD_W-1:0] sum_o,
    output logic             cout_o
);

    logic [ADD_W-1:0] b_eff;

    assign b_eff = b_i ^ {ADD_W{sub_i}};
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + (ADD_W+1)'(sub_i);

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed 32-bit multiply (radix-2 Booth) / divide (restoring) unit.
// Result, exception and ready are registered; a new start always restarts.
module multdiv_unit
    import multdiv_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Multiply: {acc_q, lo_q, qm1_q} = {P_hi, P_lo, q-1}.
    // Divide:   acc_q = remainder, lo_q = dividend shifting out / quotient shifting in.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             qm1_q, qm1_d;
    logic             neg_q, neg_d;
    logic             bzero_q, bzero_d;

    res_t             res_q, res_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             start;
    op_t              start_op;
    logic             running;
    logic             iterate;
    logic             finish;

    logic [ADD_W-1:0] add_a, add_b, add_sum, booth_sel;
    logic             add_sub, add_cout;
    logic [WIDTH-1:0] quot_s;
    logic [WIDTH:0]   prod_top;

    assign start    = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_op = bus.ctrl_MULT ? OP_MULT : OP_DIV;
    assign running  = (state_q == MULT) || (state_q == DIV);
    assign iterate  = running && (cnt_q != ITER_LAST);
    assign finish   = running && (cnt_q == ITER_LAST);

    // Adder operand selection: Booth add/sub on sign-extended P_hi, or divide trial subtract.
    always_comb begin
        add_a   = {acc_q[WIDTH-1], acc_q};
        add_b   = {opb_q[WIDTH-1], opb_q};
        add_sub = lo_q[0] & ~qm1_q;
        if (state_q == DIV) begin
            add_a   = {acc_q, lo_q[WIDTH-1]};
            add_b   = {1'b0, opb_q};
            add_sub = 1'b1;
        end
    end

    multdiv_addsub u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign booth_sel = (lo_q[0] ^ qm1_q) ? add_sum : add_a;
    assign quot_s    = neg_q ? (~lo_q + WIDTH'(1)) : lo_q;
    assign prod_top  = {acc_q, lo_q[WIDTH-1]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; a start from any state overrides the normal sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MULT, DIV: begin
                if (cnt_q == ITER_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: ;
        endcase
        if (start) begin
            state_d = (start_op == OP_MULT) ? MULT : DIV;
            cnt_d   = '0;
        end
    end

    // Datapath and output next values; the final edge still reports even if a restart lands on it.
    always_comb begin
        acc_d   = acc_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        qm1_d   = qm1_q;
        neg_d   = neg_q;
        bzero_d = bzero_q;
        res_d   = res_q;
        rdy_d   = 1'b0;
        busy_d  = (state_d != IDLE);

        if (iterate) begin
            if (state_q == MULT) begin
                acc_d = booth_sel[ADD_W-1:1];
                lo_d  = {booth_sel[0], lo_q[WIDTH-1:1]};
                qm1_d = lo_q[0];
            end else begin
                acc_d = add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
                lo_d  = {lo_q[WIDTH-2:0], add_cout};
            end
        end

        if (finish) begin
            rdy_d = 1'b1;
            if (state_q == MULT) begin
                res_d.value = lo_q;
                res_d.exc   = ~(&prod_top) & (|prod_top);
            end else if (bzero_q) begin
                res_d.value = '0;
                res_d.exc   = 1'b1;
            end else begin
                res_d.value = quot_s;
                res_d.exc   = ~neg_q & lo_q[WIDTH-1];
            end
        end

        if (start) begin
            acc_d = '0;
            qm1_d = 1'b0;
            if (start_op == OP_MULT) begin
                lo_d    = bus.data_operandA;
                opb_d   = bus.data_operandB;
                neg_d   = 1'b0;
                bzero_d = 1'b0;
            end else begin
                lo_d    = abs_val(bus.data_operandA);
                opb_d   = abs_val(bus.data_operandB);
                neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                bzero_d = (bus.data_operandB == '0);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q   <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            qm1_q   <= 1'b0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            res_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            qm1_q   <= qm1_d;
            neg_q   <= neg_d;
            bzero_q <= bzero_d;
            res_q   <= res_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.data_result    = res_q.value;
    assign bus.data_exception = res_q.exc;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed-vector bench for multdiv_unit: latency, results, exceptions, abort and reset.
module tb_multdiv_unit;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    multdiv_if bus_if ();

    multdiv_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start edge is the next rising edge; returns 1 time unit after it.
    task automatic do_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus_if.data_operandA = a;
        bus_if.data_operandB = b;
        bus_if.ctrl_MULT     = m;
        bus_if.ctrl_DIV      = d;
        @(posedge clock);
        #1;
        bus_if.ctrl_MULT     = 1'b0;
        bus_if.ctrl_DIV      = 1'b0;
        bus_if.data_operandA = 32'hDEAD_BEEF;
        bus_if.data_operandB = ~b;
    endtask

    task automatic wait_rdy(input string tag, input int exp_edges);
        int e;
        e = 0;
        for (int i = 1; i <= 45; i++) begin
            tick();
            if (bus_if.data_resultRDY) begin
                e = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, 32'(e), 32'(exp_edges));
    endtask

    task automatic run_op(input string tag, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_exc);
        do_start(m, d, a, b);
        wait_rdy(tag, 33);
        check_eq({tag, "_res"}, bus_if.data_result, exp_res);
        check_eq({tag, "_exc"}, 32'(bus_if.data_exception), 32'(exp_exc));
        tick();
        check_eq({tag, "_pulse"}, 32'(bus_if.data_resultRDY), 32'(0));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_res"},  bus_if.data_result, 32'h0);
        check_eq({tag, "_exc"},  32'(bus_if.data_exception), 32'h0);
        check_eq({tag, "_rdy"},  32'(bus_if.data_resultRDY), 32'h0);
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        reset                = 1'b1;
        bus_if.ctrl_MULT     = 1'b0;
        bus_if.ctrl_DIV      = 1'b0;
        bus_if.data_operandA = '0;
        bus_if.data_operandB = '0;
        #12;
        check_zero("reset");
        @(negedge clock);
        reset = 1'b0;

        // 7 * -3 with cycle-exact ready and busy
        do_start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        for (int k = 1; k <= 33; k++) begin
            tick();
            check_eq($sformatf("m7_rdy_e%0d", k), 32'(bus_if.data_resultRDY), 32'(k == 33));
            check_eq($sformatf("m7_busy_e%0d", k), 32'(bus_if.busy), 32'd1);
        end
        check_eq("m7_res", bus_if.data_result, 32'hFFFF_FFEB);
        check_eq("m7_exc", 32'(bus_if.data_exception), 32'd0);
        tick();
        check_eq("m7_rdy_e34", 32'(bus_if.data_resultRDY), 32'd0);
        check_eq("m7_busy_e34", 32'(bus_if.busy), 32'd0);
        check_eq("m7_hold", bus_if.data_result, 32'hFFFF_FFEB);

        run_op("m_ovf16",  1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
        run_op("m_neg1sq", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        run_op("m_minneg", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("d_100_7",  1'b0, 1'b1, 32'd100,       32'd7,         32'd14,        1'b0);
        run_op("d_ovf",    1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("d_min_1",  1'b0, 1'b1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0);
        run_op("d_m7_2",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0);

        // Divide by zero keeps full latency; previous result holds until ready
        do_start(1'b0, 1'b1, 32'd5, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            check_eq($sformatf("dz_hold_e%0d", k), bus_if.data_result, 32'hFFFF_FFFD);
            check_eq($sformatf("dz_rdy_e%0d", k), 32'(bus_if.data_resultRDY), 32'd0);
        end
        tick();
        check_eq("dz_rdy_e33", 32'(bus_if.data_resultRDY), 32'd1);
        check_eq("dz_res", bus_if.data_result, 32'h0);
        check_eq("dz_exc", 32'(bus_if.data_exception), 32'd1);

        // Restart at edge 10 aborts the divide without a ready pulse
        do_start(1'b0, 1'b1, 32'd100, 32'd7);
        seen = 0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            seen += int'(bus_if.data_resultRDY);
        end
        do_start(1'b1, 1'b0, 32'd6, 32'd7);
        seen += int'(bus_if.data_resultRDY);
        check_eq("abort_norrdy", 32'(seen), 32'd0);
        wait_rdy("abort", 33);
        check_eq("abort_res", bus_if.data_result, 32'd42);
        check_eq("abort_exc", 32'(bus_if.data_exception), 32'd0);

        run_op("both_ctrl", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

        // Back-to-back: new start on the ready edge
        do_start(1'b1, 1'b0, 32'd3, 32'd4);
        repeat (32) tick();
        do_start(1'b0, 1'b1, 32'd100, 32'd7);
        check_eq("b2b_rdy", 32'(bus_if.data_resultRDY), 32'd1);
        check_eq("b2b_res1", bus_if.data_result, 32'd12);
        wait_rdy("b2b_div", 33);
        check_eq("b2b_res2", bus_if.data_result, 32'd14);

        // Asynchronous reset between edges 15 and 16 of a multiply
        do_start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        repeat (15) tick();
        #2;
        reset = 1'b1;
        #1;
        check_zero("arst");
        @(negedge clock);
        repeat (2) tick();
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            seen += int'(bus_if.data_resultRDY);
        end
        check_eq("arst_nordy", 32'(seen), 32'd0);
        run_op("post_rst", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd9, 32'hFFFF_FFD3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Multicycle signed 32-bit multiply/divide unit in the execute stage.
- Sits beside the bitwise ALU and takes the same D/X operand latches.
- Its result joins the ALU result at the X/M latch input mux.
- The pipeline stalls from the start pulse until the unit reports ready.

Parameters:
WIDTH, 32, operand/result width; only 32 is verified. Iteration count equals WIDTH.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
data_operandA  input  32  signed multiplicand or dividend; sampled only on the start edge.
data_operandB  input  32  signed multiplier or divisor; sampled only on the start edge.
ctrl_MULT  input  1  one-cycle start pulse for multiply.
ctrl_DIV  input  1  one-cycle start pulse for divide.
data_result  output  32  product low word or quotient; registered.
data_exception  output  1  overflow / divide-by-zero flag; registered, valid with data_resultRDY.
data_resultRDY  output  1  one-cycle completion pulse; registered.
busy  output  1  high from the edge after start through the ready cycle.

Behaviour:
- Reset (async, active-high): every output reads 0; state IDLE; counter 0; operand registers 0. Reset mid-operation aborts with no ready pulse.
- States:
  - IDLE: wait for a start.
  - MULT: 32 iterations.
  - DIV: 32 iterations.
  - DONE: one cycle, then back to IDLE.
- Start edge: a rising edge with ctrl_MULT or ctrl_DIV high.
  - Latch operands and the op, clear the counter, enter MULT or DIV.
  - Both controls high: MULT wins.
- Start while busy (any state): abort the current op and restart with the new operands. No ready pulse is issued for the aborted op.
- Latency:
  - Iterations run on edges 1..32 after the start edge.
  - Edge 33 loads data_result and data_exception, and sets data_resultRDY=1 for exactly one cycle.
  - Back-to-back start on that same edge is legal: the pulse still fires and the restart begins.
- data_result and data_exception hold their values until the next ready edge. They do not change at start or on abort; they clear only on reset.
- Multiply:
  - Radix-2 Booth on a 65-bit {P_hi, P_lo, q-1} register.
  - Each iteration: 33-bit add/sub of the multiplicand into the sign-extended upper half per bits {q0, q-1}, then arithmetic shift right 1.
  - Result = product[31:0].
  - Exception = 1 when product[63:31] is not all-zeros or all-ones (signed overflow).
- Divide:
  - Take |A| and |B| (two's complement; |-2^31| fits as unsigned 32).
  - 32-step restoring unsigned division with a 33-bit remainder.
  - On the final edge, negate the quotient if sign(A)^sign(B). The remainder is discarded.
  - Truncates toward zero.
  - B==0: result 0x00000000, exception 1, full 33-cycle latency kept.
  - A=0x80000000, B=-1: result 0x80000000, exception 1.
- Counter: 6 bits, saturates at 32; no wrap-around within one op.
- Operand inputs may change freely after the start edge.

Decomposition:
- Shared package multdiv_pkg:
  - state encoding IDLE/MULT/DIV/DONE;
  - op codes OP_MULT=1'b0, OP_DIV=1'b1;
  - ITER_LAST=6'd32.
- One sub-module: multdiv_addsub, a 33-bit adder/subtractor with sub input and carry-out. It is shared by the Booth and restoring-divide datapaths and instantiated once.

Test Plan:
- A=7, B=-3, ctrl_MULT at edge 0 → RDY high only in cycle after edge 33; result 0xFFFFFFEB; exception 0; busy high edges 1..33.
- A=0x00010000, B=0x00010000, MULT → result 0x00000000, exception 1. Then A=-1, B=-1 → result 1, exception 0.
- A=-7, B=2, ctrl_DIV → result 0xFFFFFFFD. A=100, B=7 → 14. A=0x80000000, B=-1 → 0x80000000, exception 1.
- A=5, B=0, DIV → RDY at edge 33, result 0, exception 1. Previous result holds at 0xFFFFFFFD until that edge.
- DIV 100/7 started, ctrl_MULT with A=6, B=7 at edge 10 → no RDY at edge 33; RDY at edge 43 with result 42. Both ctrl high together → multiply performed.
- Reset asserted asynchronously between edges 15 and 16 of a multiply → outputs 0 immediately, no RDY ever. A new start after deassert completes normally.
